// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller: coin encoding, FSM states,
// and slot count. Used by vend_sequencer and change_dispenser (DOLLAR_CHANGE_EN aware).
package vend_pkg;

    localparam int VEND_NUM_ITEMS = 9;
    localparam int NICKEL_CENTS   = 5;

    typedef enum logic [2:0] {
        COIN_5   = 3'd0,
        COIN_10  = 3'd1,
        COIN_25  = 3'd2,
        COIN_50  = 3'd3,
        COIN_100 = 3'd4,
        COIN_500 = 3'd5
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } state_e;

    // Codes 6 and 7 map to 0 cents; callers reject them via coin_known().
    function automatic logic [8:0] coin_cents(input logic [2:0] t);
        case (t)
            3'd0:    return 9'd5;
            3'd1:    return 9'd10;
            3'd2:    return 9'd25;
            3'd3:    return 9'd50;
            3'd4:    return 9'd100;
            3'd5:    return 9'd500;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic coin_known(input logic [2:0] t);
        return t <= 3'd5;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy coin pick for the change hopper: largest dispensable coin <= amount.
// DOLLAR_CHANGE_EN adds the 100c coin to the set of dispensable coins.
module change_dispenser
    import vend_pkg::*;
(
    input  logic [8:0] i_amount,
    output logic [2:0] o_coin_type,
    output logic [8:0] o_coin_val
);

    // Later checks override earlier ones, so the largest fitting coin wins.
    always_comb begin
        o_coin_type = COIN_5;
        o_coin_val  = 9'd5;
        if (i_amount >= 9'd10) begin
            o_coin_type = COIN_10;
            o_coin_val  = 9'd10;
        end
        if (i_amount >= 9'd25) begin
            o_coin_type = COIN_25;
            o_coin_val  = 9'd25;
        end
`ifdef DOLLAR_CHANGE_EN
        if (i_amount >= 9'd100) begin
            o_coin_type = COIN_100;
            o_coin_val  = 9'd100;
        end
`else
`endif
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: price table, credit, event arbitration, vend and
// change handshakes, LEDs and display. Change coin set depends on DOLLAR_CHANGE_EN.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = VEND_NUM_ITEMS,
    parameter int MAX_CREDIT = 500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coin_valid,
    input  logic [2:0]           coin_type,
    output logic                 coin_reject,
    input  logic                 sel_valid,
    input  logic [3:0]           sel_idx,
    output logic                 sel_denied,
    input  logic                 cancel,
    input  logic                 price_we,
    input  logic [3:0]           price_addr,
    input  logic [6:0]           price_data,
    output logic                 vend_req,
    output logic [3:0]           vend_idx,
    input  logic                 vend_ack,
    output logic                 coin_out_req,
    output logic [2:0]           coin_out_type,
    input  logic                 coin_out_ack,
    output logic [8:0]           credit,
    output logic [NUM_ITEMS-1:0] item_ok,
    output logic [NUM_ITEMS-1:0] item_oos,
    output logic [8:0]           disp_value,
    output logic                 busy
);

    localparam logic [9:0] MAX_C       = 10'(MAX_CREDIT);
    localparam logic [6:0] MAX_NICKELS = 7'(MAX_CREDIT / NICKEL_CENTS);

    state_e     r_state, w_state_nxt;
    logic [8:0] r_credit, w_credit_nxt;
    logic [3:0] r_vend_idx, w_vend_idx_nxt;
    logic       r_coin_reject, w_reject_nxt;
    logic       r_sel_denied, w_denied_nxt;
    logic       r_slot_vld, w_slot_vld_nxt;
    logic [3:0] r_slot_idx, w_slot_idx_nxt;
    logic [8:0] r_price [NUM_ITEMS];

    logic       w_sel_in_range, w_slot_in_range, w_sel_ok, w_coin_ok, w_price_ok;
    logic [8:0] w_sel_price, w_slot_price, w_coin_val, w_chg_val;
    logic [9:0] w_coin_sum;
    logic [2:0] w_chg_type;

    change_dispenser u_chg (
        .i_amount    (r_credit),
        .o_coin_type (w_chg_type),
        .o_coin_val  (w_chg_val)
    );

    assign w_sel_in_range  = 32'(sel_idx) < NUM_ITEMS;
    assign w_slot_in_range = 32'(r_slot_idx) < NUM_ITEMS;

    always_comb begin
        w_sel_price  = '0;
        w_slot_price = '0;
        if (w_sel_in_range)  w_sel_price  = r_price[sel_idx];
        if (w_slot_in_range) w_slot_price = r_price[r_slot_idx];
    end

    assign w_sel_ok   = w_sel_in_range && (w_sel_price != '0) && (r_credit >= w_sel_price);
    assign w_coin_val = coin_cents(coin_type);
    assign w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok  = coin_known(coin_type) && (w_coin_sum <= MAX_C);
    assign w_price_ok = price_we && (32'(price_addr) < NUM_ITEMS) && (price_data <= MAX_NICKELS)
                        && (r_state == ST_IDLE || r_state == ST_CREDIT);

    // Arbitration: cancel > selection > coin; a coin losing arbitration is bounced.
    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_vend_idx_nxt = r_vend_idx;
        w_reject_nxt   = 1'b0;
        w_denied_nxt   = 1'b0;
        w_slot_vld_nxt = r_slot_vld;
        w_slot_idx_nxt = r_slot_idx;
        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    w_reject_nxt = coin_valid;
                    if (r_state == ST_CREDIT) w_state_nxt = ST_CHANGE;
                end else if (sel_valid) begin
                    w_reject_nxt = coin_valid;
                    if (r_state == ST_IDLE) begin
                        w_slot_vld_nxt = 1'b1;
                        w_slot_idx_nxt = sel_idx;
                    end
                    if (w_sel_ok) begin
                        w_state_nxt    = ST_VEND;
                        w_vend_idx_nxt = sel_idx;
                    end else begin
                        w_denied_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_credit_nxt   = w_coin_sum[8:0];
                        w_state_nxt    = ST_CREDIT;
                        w_slot_vld_nxt = 1'b0;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                w_reject_nxt = coin_valid;
                if (vend_ack) begin
                    w_credit_nxt = r_credit - r_price[r_vend_idx];
                    w_state_nxt  = (w_credit_nxt != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                w_reject_nxt = coin_valid;
                if (coin_out_ack) begin
                    w_credit_nxt = r_credit - w_chg_val;
                    if (w_credit_nxt == '0) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_vend_idx    <= '0;
            r_coin_reject <= 1'b0;
            r_sel_denied  <= 1'b0;
            r_slot_vld    <= 1'b0;
            r_slot_idx    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_vend_idx    <= w_vend_idx_nxt;
            r_coin_reject <= w_reject_nxt;
            r_sel_denied  <= w_denied_nxt;
            r_slot_vld    <= w_slot_vld_nxt;
            r_slot_idx    <= w_slot_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_price[i] <= '0;
        end else if (w_price_ok) begin
            r_price[price_addr] <= 9'({2'b00, price_data} * NICKEL_CENTS);
        end
    end

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_led
        assign item_oos[g] = (r_price[g] == '0);
        assign item_ok[g]  = (r_price[g] != '0) && (r_credit >= r_price[g]);
    end

    assign coin_reject   = r_coin_reject;
    assign sel_denied    = r_sel_denied;
    assign credit        = r_credit;
    assign vend_req      = (r_state == ST_VEND);
    assign vend_idx      = r_vend_idx;
    assign coin_out_req  = (r_state == ST_CHANGE);
    assign coin_out_type = (r_state == ST_CHANGE) ? w_chg_type : 3'd0;
    assign busy          = (r_state == ST_VEND) || (r_state == ST_CHANGE);
    assign disp_value    = (r_state == ST_IDLE) ? (r_slot_vld ? w_slot_price : 9'd0) : r_credit;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer; refund expectations follow
// DOLLAR_CHANGE_EN when it is defined for the build.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [2:0] coin_type = '0;
    logic       coin_reject;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_idx = '0;
    logic       sel_denied;
    logic       cancel = 1'b0;
    logic       price_we = 1'b0;
    logic [3:0] price_addr = '0;
    logic [6:0] price_data = '0;
    logic       vend_req;
    logic [3:0] vend_idx;
    logic       vend_ack = 1'b0;
    logic       coin_out_req;
    logic [2:0] coin_out_type;
    logic       coin_out_ack = 1'b0;
    logic [8:0] credit;
    logic [8:0] item_ok;
    logic [8:0] item_oos;
    logic [8:0] disp_value;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vend_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_type(coin_type), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_denied(sel_denied),
        .cancel(cancel),
        .price_we(price_we), .price_addr(price_addr), .price_data(price_data),
        .vend_req(vend_req), .vend_idx(vend_idx), .vend_ack(vend_ack),
        .coin_out_req(coin_out_req), .coin_out_type(coin_out_type), .coin_out_ack(coin_out_ack),
        .credit(credit), .item_ok(item_ok), .item_oos(item_oos),
        .disp_value(disp_value), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] t);
        coin_valid = 1'b1; coin_type = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [3:0] idx);
        sel_valid = 1'b1; sel_idx = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic write_price(input logic [3:0] a, input logic [6:0] d);
        price_we = 1'b1; price_addr = a; price_data = d;
        tick();
        price_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        n_checks++;
        if (credit !== 9'd0 || disp_value !== 9'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_credit: credit=%0d disp=%0d busy=%b want 0/0/0", credit, disp_value, busy);
        end
        n_checks++;
        if (vend_req !== 1'b0 || coin_out_req !== 1'b0 || coin_reject !== 1'b0 || sel_denied !== 1'b0) begin
            n_fail++; $display("FAIL reset_hs: vreq=%b creq=%b rej=%b den=%b want 0", vend_req, coin_out_req, coin_reject, sel_denied);
        end
        n_checks++;
        if (vend_idx !== 4'd0 || coin_out_type !== 3'd0) begin
            n_fail++; $display("FAIL reset_idx: vidx=%0d ctype=%0d want 0/0", vend_idx, coin_out_type);
        end
        n_checks++;
        if (item_ok !== 9'h000 || item_oos !== 9'h1FF) begin
            n_fail++; $display("FAIL reset_leds: ok=%h oos=%h want 000/1ff", item_ok, item_oos);
        end
    endtask

    task automatic test_credit();
        write_price(4'd0, 7'd15);
        n_checks++;
        if (item_oos !== 9'h1FE) begin n_fail++; $display("FAIL price_a1_oos: got %h want 1fe", item_oos); end
        put_coin(3'd2);
        put_coin(3'd2);
        n_checks++;
        if (credit !== 9'd50 || item_ok[0] !== 1'b0) begin
            n_fail++; $display("FAIL credit_50: credit=%0d ok0=%b want 50/0", credit, item_ok[0]);
        end
        put_coin(3'd3);
        n_checks++;
        if (credit !== 9'd100 || item_ok !== 9'h001 || disp_value !== 9'd100) begin
            n_fail++; $display("FAIL credit_100: credit=%0d ok=%h disp=%0d want 100/001/100", credit, item_ok, disp_value);
        end
    endtask

    task automatic test_vend();
        select(4'd0);
        n_checks++;
        if (vend_req !== 1'b1 || vend_idx !== 4'd0 || busy !== 1'b1 || sel_denied !== 1'b0) begin
            n_fail++; $display("FAIL vend_start: req=%b idx=%0d busy=%b den=%b want 1/0/1/0", vend_req, vend_idx, busy, sel_denied);
        end
        // Coin and price write while vending are both refused.
        coin_valid = 1'b1; coin_type = 3'd0;
        price_we = 1'b1; price_addr = 4'd3; price_data = 7'd1;
        tick();
        coin_valid = 1'b0; price_we = 1'b0;
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd100 || item_oos[3] !== 1'b1 || vend_req !== 1'b1) begin
            n_fail++; $display("FAIL vend_busy_ignore: rej=%b credit=%0d oos3=%b req=%b want 1/100/1/1", coin_reject, credit, item_oos[3], vend_req);
        end
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        n_checks++;
        if (vend_req !== 1'b0 || credit !== 9'd25 || coin_out_req !== 1'b1 || coin_out_type !== 3'd2 || disp_value !== 9'd25) begin
            n_fail++; $display("FAIL vend_ack: vreq=%b credit=%0d creq=%b type=%0d disp=%0d want 0/25/1/2/25", vend_req, credit, coin_out_req, coin_out_type, disp_value);
        end
        coin_out_ack = 1'b1; tick(); coin_out_ack = 1'b0;
        n_checks++;
        if (coin_out_req !== 1'b0 || credit !== 9'd0 || busy !== 1'b0 || disp_value !== 9'd0) begin
            n_fail++; $display("FAIL change_done: creq=%b credit=%0d busy=%b disp=%0d want 0/0/0/0", coin_out_req, credit, busy, disp_value);
        end
        vend_ack = 1'b1; coin_out_ack = 1'b1; tick(); vend_ack = 1'b0; coin_out_ack = 1'b0;
        n_checks++;
        if (credit !== 9'd0 || busy !== 1'b0 || coin_out_req !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack: credit=%0d busy=%b creq=%b want 0/0/0", credit, busy, coin_out_req);
        end
    endtask

    task automatic test_overflow_refund();
        int exp_t, exp_v, exp_n, cnt, bad;
`ifdef DOLLAR_CHANGE_EN
        exp_t = 4; exp_v = 100; exp_n = 5;
`else
        exp_t = 2; exp_v = 25; exp_n = 20;
`endif
        put_coin(3'd6);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd0) begin
            n_fail++; $display("FAIL invalid_coin: rej=%b credit=%0d want 1/0", coin_reject, credit);
        end
        put_coin(3'd5);
        put_coin(3'd0);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 9'd500) begin
            n_fail++; $display("FAIL overflow_coin: rej=%b credit=%0d want 1/500", coin_reject, credit);
        end
        tick();
        n_checks++;
        if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: rej=%b want 0", coin_reject); end
        cancel = 1'b1; tick(); cancel = 1'b0;
        cnt = 0; bad = 0;
        while (coin_out_req === 1'b1 && cnt < 30) begin
            if (coin_out_type !== 3'(exp_t)) bad++;
            if (credit !== 9'(500 - cnt * exp_v)) bad++;
            coin_out_ack = 1'b1; tick(); coin_out_ack = 1'b0;
            cnt++;
        end
        n_checks++;
        if (cnt != exp_n || bad != 0 || credit !== 9'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL refund_500: coins=%0d bad=%0d credit=%0d busy=%b want %0d/0/0/0", cnt, bad, credit, busy, exp_n);
        end
    endtask

    task automatic test_deny();
        select(4'd2);
        n_checks++;
        if (sel_denied !== 1'b1 || busy !== 1'b0 || credit !== 9'd0) begin
            n_fail++; $display("FAIL deny_oos: den=%b busy=%b credit=%0d want 1/0/0", sel_denied, busy, credit);
        end
        select(4'd12);
        n_checks++;
        if (sel_denied !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL deny_range: den=%b busy=%b want 1/0", sel_denied, busy);
        end
        write_price(4'd1, 7'd40);
        write_price(4'd2, 7'd101);
        n_checks++;
        if (item_oos !== 9'h1FC) begin n_fail++; $display("FAIL price_limit: oos=%h want 1fc", item_oos); end
        select(4'd1);
        n_checks++;
        if (sel_denied !== 1'b1 || disp_value !== 9'd200) begin
            n_fail++; $display("FAIL idle_disp: den=%b disp=%0d want 1/200", sel_denied, disp_value);
        end
        put_coin(3'd1);
        select(4'd2);
        n_checks++;
        if (sel_denied !== 1'b1 || credit !== 9'd10 || busy !== 1'b0 || disp_value !== 9'd10) begin
            n_fail++; $display("FAIL deny_credit: den=%b credit=%0d busy=%b disp=%0d want 1/10/0/10", sel_denied, credit, busy, disp_value);
        end
    endtask

    task automatic test_cancel_coin();
        put_coin(3'd2);
        cancel = 1'b1; coin_valid = 1'b1; coin_type = 3'd0;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        n_checks++;
        if (coin_reject !== 1'b1 || coin_out_req !== 1'b1 || coin_out_type !== 3'd2 || credit !== 9'd35) begin
            n_fail++; $display("FAIL cancel_coin: rej=%b creq=%b type=%0d credit=%0d want 1/1/2/35", coin_reject, coin_out_req, coin_out_type, credit);
        end
        coin_out_ack = 1'b1; tick(); coin_out_ack = 1'b0;
        n_checks++;
        if (coin_out_req !== 1'b1 || coin_out_type !== 3'd1 || credit !== 9'd10) begin
            n_fail++; $display("FAIL change_10: creq=%b type=%0d credit=%0d want 1/1/10", coin_out_req, coin_out_type, credit);
        end
        coin_out_ack = 1'b1; tick(); coin_out_ack = 1'b0;
        n_checks++;
        if (coin_out_req !== 1'b0 || credit !== 9'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL change_35_done: creq=%b credit=%0d busy=%b want 0/0/0", coin_out_req, credit, busy);
        end
    endtask

    task automatic test_sel_coin();
        put_coin(3'd4);
        sel_valid = 1'b1; sel_idx = 4'd0; coin_valid = 1'b1; coin_type = 3'd0;
        tick();
        sel_valid = 1'b0; coin_valid = 1'b0;
        n_checks++;
        if (coin_reject !== 1'b1 || vend_req !== 1'b1 || credit !== 9'd100) begin
            n_fail++; $display("FAIL sel_coin: rej=%b vreq=%b credit=%0d want 1/1/100", coin_reject, vend_req, credit);
        end
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        n_checks++;
        if (coin_out_req !== 1'b1 || credit !== 9'd25) begin
            n_fail++; $display("FAIL sel_coin_change: creq=%b credit=%0d want 1/25", coin_out_req, credit);
        end
    endtask

    task automatic test_reset_mid_change();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (coin_out_req !== 1'b0 || busy !== 1'b0 || coin_out_type !== 3'd0) begin
            n_fail++; $display("FAIL async_drop: creq=%b busy=%b type=%0d want 0/0/0", coin_out_req, busy, coin_out_type);
        end
        #20 rst_n = 1'b1;
        tick();
        n_checks++;
        if (credit !== 9'd0 || item_oos !== 9'h1FF || item_ok !== 9'h000 || disp_value !== 9'd0) begin
            n_fail++; $display("FAIL post_reset: credit=%0d oos=%h ok=%h disp=%0d want 0/1ff/000/0", credit, item_oos, item_ok, disp_value);
        end
    endtask

    initial begin
        test_reset();
        test_credit();
        test_vend();
        test_overflow_refund();
        test_deny();
        test_cancel_coin();
        test_sel_coin();
        test_reset_mid_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the vending machine: owns the nine-entry price table, accumulates inserted credit, arbitrates selection/cancel/coin events, and sequences the vend and change-dispense handshakes. Sits between the coin/button front end and the product motors and coin hopper. Drives the green/red item LEDs and the value shown on the 7-segment display.

## Interface
- `NUM_ITEMS`, default 9: number of slots (A1..C3 = index 0..8).
- `MAX_CREDIT`, default 500: maximum accepted credit in cents.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  single-cycle coin pulse.
- `coin_type`  in  3  0=5c, 1=10c, 2=25c, 3=50c, 4=100c, 5=500c, 6-7 invalid.
- `coin_reject`  out  1  one-cycle pulse: coin returned by the acceptor.
- `sel_valid`  in  1  single-cycle selection pulse.
- `sel_idx`  in  4  selected slot.
- `sel_denied`  out  1  one-cycle pulse: selection refused.
- `cancel`  in  1  single-cycle cancel/refund pulse.
- `price_we`  in  1  price table write.
- `price_addr`  in  4  slot to write.
- `price_data`  in  7  price in nickels; 0 means out of stock.
- `vend_req`  out  1  motor request, held until acked.
- `vend_idx`  out  4  slot to vend, stable while `vend_req`.
- `vend_ack`  in  1  motor done.
- `coin_out_req`  out  1  hopper request, held until acked.
- `coin_out_type`  out  3  coin to eject (`coin_type` encoding), stable while requested.
- `coin_out_ack`  in  1  hopper done.
- `credit`  out  9  current credit in cents.
- `item_ok`  out  NUM_ITEMS  green LEDs: price≠0 and credit≥price.
- `item_oos`  out  NUM_ITEMS  red LEDs: price==0.
- `disp_value`  out  9  cents for the 7-segment driver.
- `busy`  out  1  high in VEND or CHANGE.

## Operation
- States:
  - IDLE (credit 0).
  - CREDIT (credit>0).
  - VEND.
  - CHANGE.
- Event priority per cycle: cancel > sel_valid > coin_valid. A lower-priority coin in the same cycle gets `coin_reject`. A lower-priority selection is dropped silently.
- Coin, IDLE/CREDIT: if valid and credit+value ≤ MAX_CREDIT, add the value and enter CREDIT. Otherwise pulse `coin_reject`. In VEND/CHANGE, every coin is rejected.
- Selection, IDLE/CREDIT:
  - idx ≥ NUM_ITEMS, price 0, or credit < price: pulse `sel_denied`. In IDLE, a denied or accepted-price-check selection latches the slot so the display shows its price.
  - Otherwise enter VEND with `vend_idx`=idx.
- VEND: hold `vend_req` until `vend_ack` is sampled. Then credit ← credit − price×5 and go to CHANGE if credit>0, else IDLE.
- Cancel: in CREDIT, enter CHANGE with the full credit as refund. Ignored in IDLE, VEND and CHANGE.
- CHANGE: greedy selection of the largest dispensable coin ≤ remaining credit, with `coin_out_req` held. On `coin_out_ack`, subtract that coin's value. At credit 0, return to IDLE. Amounts are always multiples of 5, so termination is guaranteed.
- Price writes are accepted only in IDLE/CREDIT with `price_data` ≤ MAX_CREDIT/5. Otherwise they are ignored. Internal price = `price_data`×5, 9-bit, no overflow.
- `disp_value`:
  - IDLE: latched slot price, or 0.
  - CREDIT: credit.
  - VEND: credit.
  - CHANGE: remaining credit.

## Timing
- Reset values:
  - State IDLE.
  - All prices 0.
  - `credit`, `disp_value`, `vend_req`, `coin_out_req`, `coin_reject`, `sel_denied`, `busy` all 0.
  - `vend_idx`, `coin_out_type` 0.
  - `item_ok` all 0; `item_oos` all 1.
- Coin or price write at edge N: `credit` and LEDs update at N+1. `coin_reject` is high during N+1.
- Accepted selection at N: `vend_req` high from N+1. `sel_denied` is high during N+1 when refused.
- Ack at N: request drops at N+1 and credit updates at N+1. The next change coin is requested from N+1; there are no bubble cycles.
- An ack while no request is outstanding is ignored.
- `item_ok`/`item_oos` are combinational from registered credit and prices.
- Reset mid-VEND or mid-CHANGE abandons the transaction; the credit is lost. Handshake outputs drop asynchronously.

## Configuration
- `DOLLAR_CHANGE_EN` defined: change uses 100c, 25c, 10c and 5c coins.
- Undefined: change uses only 25c, 10c and 5c coins, so $1.00 change is four quarters.
- No other behaviour differs between the two builds.

## Structure
- `vend_pkg`:
  - coin type encoding and the cents-value function;
  - state enum;
  - `NUM_ITEMS`;
  - nickel-to-cents constant.
- Sub-module `change_dispenser`: takes the remaining amount and returns `coin_out_type` and coin value. It is combinational greedy selection with the `DOLLAR_CHANGE_EN` branch; the parent owns the handshake.

## Test plan
- Write price A1=15 nickels (75c); insert 25c ×2 -> `credit`=50, `item_ok[0]`=0. Insert 50c -> `credit`=100, `item_ok[0]`=1.
- Select 0 with 100c credit -> `vend_req`, `vend_idx`=0. Ack -> CHANGE, one 25c ejected, IDLE with `credit`=0.
- Insert 500c, then 5c -> second coin gets `coin_reject`, `credit`=500. Cancel -> refund of 5×100c (with macro) or 20×25c (without).
- Select an OOS slot (price 0) or idx 12 -> `sel_denied` pulse, state unchanged. In IDLE with A2=40 nickels, select 1 -> `disp_value`=200.
- Same-cycle cancel+coin at credit 35 -> coin rejected, refund 25c+10c. Same-cycle sel+coin -> coin rejected.
- Reset asserted during CHANGE with `coin_out_req` high -> request drops immediately. Prices and credit are 0 and `item_oos` is all 1 afterwards.
